// File: rtl/mem_bus_bridge.sv
`timescale 1ns/1ps
// Bridges the multicycle core's memory port to the on-chip RAM (req/ack with timeout)
// and a small MMIO block holding the LED register, a free-running cycle counter and a W1C status register.
module mem_bus_bridge #(
    parameter int RAM_ADDR_W = 12,
    parameter int LED_W      = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic                  ram_ack,
    input  logic [31:0]           ram_rdata,
    output logic [LED_W-1:0]      leds
);

    localparam logic [31:0] LED_ADDR  = 32'h8000_0000;
    localparam logic [31:0] CNT_ADDR  = 32'h8000_0004;
    localparam logic [31:0] STAT_ADDR = 32'h8000_0008;
    localparam int          TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;

    state_t          state;
    logic [31:0]     cycle_cnt;
    logic [2:0]      status;
    logic [TO_W-1:0] wait_cnt;
    logic            pend_read;

    logic        req;
    logic        is_wr;
    logic        misaligned;
    logic        hit_ram;
    logic        hit_led;
    logic        hit_cnt;
    logic        hit_stat;
    logic [31:0] mmio_rdata;
    logic [2:0]  status_set;
    logic [2:0]  status_clr;

    // A simultaneous read+write is handled as a write. Status sets are ORed in after
    // the W1C clear so an event in the same cycle as its clear is never lost.
    always_comb begin
        req        = cpu_read | cpu_write;
        is_wr      = cpu_write;
        misaligned = (cpu_addr[1:0] != 2'b00);
        hit_ram    = (cpu_addr[31:RAM_ADDR_W+2] == '0);
        hit_led    = (cpu_addr == LED_ADDR);
        hit_cnt    = (cpu_addr == CNT_ADDR);
        hit_stat   = (cpu_addr == STAT_ADDR);

        mmio_rdata = 32'h0;
        if (hit_led)
            mmio_rdata = 32'(leds);
        else if (hit_cnt)
            mmio_rdata = cycle_cnt;
        else if (hit_stat)
            mmio_rdata = {29'h0, status};

        status_set = 3'b000;
        status_clr = 3'b000;
        if (state == IDLE && req) begin
            status_set[0] = misaligned;
            status_set[1] = cpu_read & cpu_write;
            if (hit_stat && is_wr)
                status_clr = cpu_wdata[2:0];
        end
        if (state == RAM_WAIT && !ram_ack && wait_cnt == TO_LAST)
            status_set[2] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cycle_cnt <= 32'h0;
            status    <= 3'b000;
            wait_cnt  <= '0;
            pend_read <= 1'b0;
            cpu_rdata <= 32'h0;
            cpu_ready <= 1'b0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 32'h0;
            leds      <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            status    <= (status & ~status_clr) | status_set;
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        pend_read <= !is_wr;
                        if (misaligned) begin
                            if (!is_wr)
                                cpu_rdata <= 32'h0;
                            state <= RESP;
                        end else if (hit_ram) begin
                            ram_req   <= 1'b1;
                            ram_we    <= is_wr;
                            ram_addr  <= cpu_addr[RAM_ADDR_W+1:2];
                            ram_wdata <= cpu_wdata;
                            wait_cnt  <= '0;
                            state     <= RAM_WAIT;
                        end else begin
                            if (is_wr) begin
                                if (hit_led)
                                    leds <= cpu_wdata[LED_W-1:0];
                            end else begin
                                cpu_rdata <= mmio_rdata;
                            end
                            state <= RESP;
                        end
                    end
                end
                // ram_* outputs are left untouched here so the RAM sees a stable request
                RAM_WAIT: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        if (pend_read)
                            cpu_rdata <= ram_rdata;
                        state <= RESP;
                    end else if (wait_cnt == TO_LAST) begin
                        ram_req <= 1'b0;
                        if (pend_read)
                            cpu_rdata <= 32'hDEAD_BEEF;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_bus_bridge: each test queues the expected response of an
// access, drives it, then pops and compares latency, RAM request length and read data.
module tb_mem_bus_bridge;

    localparam int RAM_ADDR_W = 12;
    localparam int LED_W      = 8;
    localparam int TIMEOUT    = 16;

    localparam logic [31:0] LED_A  = 32'h8000_0000;
    localparam logic [31:0] CNT_A  = 32'h8000_0004;
    localparam logic [31:0] STAT_A = 32'h8000_0008;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cpu_read = 1'b0;
    logic                  cpu_write = 1'b0;
    logic [31:0]           cpu_addr = 32'h0;
    logic [31:0]           cpu_wdata = 32'h0;
    logic [31:0]           cpu_rdata;
    logic                  cpu_ready;
    logic                  ram_req;
    logic                  ram_we;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic                  ram_ack = 1'b0;
    logic [31:0]           ram_rdata = 32'h0;
    logic [LED_W-1:0]      leds;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          ack_delay = 0;
    logic [31:0] ack_data = 32'h0;
    int          edge_count = 0;

    typedef struct {
        logic [31:0] rdata;
        bit          check_rdata;
        int          latency;
        int          req_cycles;
    } exp_t;
    exp_t sb[$];

    logic [31:0]           obs_rdata;
    int                    obs_lat;
    int                    obs_req;
    logic                  obs_ready_after;
    logic [RAM_ADDR_W-1:0] obs_ram_addr;
    logic                  obs_we;
    logic [31:0]           obs_wdata;

    mem_bus_bridge #(.RAM_ADDR_W(RAM_ADDR_W), .LED_W(LED_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata), .leds(leds)
    );

    always #5 clk = ~clk;

    // Reference cycle count: clock edges seen since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_count <= 0;
        else        edge_count <= edge_count + 1;
    end

    // RAM model: acks in the ack_delay-th cycle of a request; ack_delay 0 never acks
    initial begin
        int age;
        age = 0;
        forever begin
            @(posedge clk); #1;
            ram_ack = 1'b0;
            if (ram_req === 1'b1) begin
                age++;
                if (age == ack_delay) begin
                    ram_ack   = 1'b1;
                    ram_rdata = ack_data;
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void push_exp(input logic [31:0] rdata, input bit chk, input int lat, input int reqc);
        exp_t e;
        e.rdata       = rdata;
        e.check_rdata = chk;
        e.latency     = lat;
        e.req_cycles  = reqc;
        sb.push_back(e);
    endfunction

    // Presents one access, waits (bounded) for cpu_ready, then drops the request.
    // Latency counts the accept cycle, so a 2-cycle access reports 2.
    task automatic bus_access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bit seen_req;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk); #1;
        obs_req  = 0;
        obs_lat  = -1;
        seen_req = 1'b0;
        for (int k = 1; k <= 40 && obs_lat < 0; k++) begin
            if (ram_req === 1'b1) begin
                obs_req++;
                if (!seen_req) begin
                    seen_req     = 1'b1;
                    obs_ram_addr = ram_addr;
                    obs_we       = ram_we;
                    obs_wdata    = ram_wdata;
                end
            end
            @(posedge clk); #1;
            if (cpu_ready === 1'b1) begin
                obs_lat   = k + 1;
                obs_rdata = cpu_rdata;
            end
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(posedge clk); #1;
        obs_ready_after = cpu_ready;
    endtask

    task automatic test_reset();
        exp_t e;
        int   ready_seen;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (cpu_ready !== 1'b0 || ram_req !== 1'b0 || ram_we !== 1'b0 || cpu_rdata !== 32'h0 ||
            leds !== 8'h00 || ram_addr !== 12'h000 || ram_wdata !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got ready=%b req=%b we=%b rdata=%h leds=%h addr=%h wdata=%h, expected all zero",
                     cpu_ready, ram_req, ram_we, cpu_rdata, leds, ram_addr, ram_wdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        push_exp(32'h0, 1'b0, 2, 0);
        bus_access(1'b0, 1'b1, LED_A, 32'h0000_005A);
        e = sb.pop_front();
        tests_run++;
        if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 || leds !== 8'h5A) begin
            tests_failed++;
            $display("[TB] FAIL reset_led_prep: got lat=%0d req=%0d leds=%h, expected lat=%0d req=%0d leds=5a",
                     obs_lat, obs_req, leds, e.latency, e.req_cycles);
        end

        push_exp(32'h0, 1'b1, 2, 0);
        bus_access(1'b1, 1'b0, 32'h8000_0001, 32'h0);
        e = sb.pop_front();
        tests_run++;
        if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 || obs_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL reset_status_prep: got lat=%0d req=%0d rdata=%h, expected lat=%0d req=%0d rdata=%h",
                     obs_lat, obs_req, obs_rdata, e.latency, e.req_cycles, e.rdata);
        end

        ack_delay = 0;
        cpu_read  = 1'b1;
        cpu_addr  = 32'h0000_0020;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (ram_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_req_pending: got ram_req=%b, expected 1", ram_req);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (ram_req !== 1'b0 || leds !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: got ram_req=%b leds=%h, expected ram_req=0 leds=00", ram_req, leds);
        end
        cpu_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (cpu_ready === 1'b1) ready_seen++;
        end
        tests_run++;
        if (ready_seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_ready: got %0d ready pulses, expected 0", ready_seen);
        end

        push_exp(32'h0, 1'b1, 2, 0);
        bus_access(1'b1, 1'b0, STAT_A, 32'h0);
        e = sb.pop_front();
        tests_run++;
        if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 || obs_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL reset_status_cleared: got lat=%0d req=%0d rdata=%h, expected lat=%0d req=%0d rdata=%h",
                     obs_lat, obs_req, obs_rdata, e.latency, e.req_cycles, e.rdata);
        end
    endtask

    task automatic test_led();
        exp_t e;
        logic [31:0] wd [4]  = '{32'h0000_00A5, 32'h0, 32'hFFFF_FF12, 32'h0};
        logic        wr [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exr[4]  = '{32'h0, 32'h0000_00A5, 32'h0, 32'h0000_0012};
        logic [7:0]  exl[4]  = '{8'hA5, 8'hA5, 8'h12, 8'h12};
        for (int i = 0; i < 4; i++) begin
            push_exp(exr[i], !wr[i], 2, 0);
            bus_access(!wr[i], wr[i], LED_A, wd[i]);
            e = sb.pop_front();
            tests_run++;
            if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 ||
                (e.check_rdata && obs_rdata !== e.rdata) || leds !== exl[i]) begin
                tests_failed++;
                $display("[TB] FAIL led_access_%0d: got lat=%0d req=%0d rdata=%h leds=%h, expected lat=%0d req=%0d rdata=%h leds=%h",
                         i, obs_lat, obs_req, obs_rdata, leds, e.latency, e.req_cycles, e.rdata, exl[i]);
            end
        end
    endtask

    task automatic test_ram_read_write();
        exp_t e;
        ack_delay = 3;
        ack_data  = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b1, 5, 3);
        bus_access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        e = sb.pop_front();
        tests_run++;
        if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 || obs_rdata !== e.rdata ||
            obs_ram_addr !== 12'h004 || obs_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ram_read: got lat=%0d req=%0d rdata=%h addr=%h we=%b, expected lat=%0d req=%0d rdata=%h addr=004 we=0",
                     obs_lat, obs_req, obs_rdata, obs_ram_addr, obs_we, e.latency, e.req_cycles, e.rdata);
        end

        ack_delay = 1;
        ack_data  = 32'h5555_AAAA;
        push_exp(32'h1234_5678, 1'b1, 3, 1);
        bus_access(1'b0, 1'b1, 32'h0000_3FFC, 32'hCAFE_F00D);
        e = sb.pop_front();
        tests_run++;
        if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 || obs_rdata !== e.rdata ||
            obs_ram_addr !== 12'hFFF || obs_we !== 1'b1 || obs_wdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("[TB] FAIL ram_write_top: got lat=%0d req=%0d rdata=%h addr=%h we=%b wdata=%h, expected lat=%0d req=%0d rdata=%h addr=fff we=1 wdata=cafef00d",
                     obs_lat, obs_req, obs_rdata, obs_ram_addr, obs_we, obs_wdata, e.latency, e.req_cycles, e.rdata);
        end
    endtask

    task automatic test_ram_timeout();
        exp_t e;
        logic        rd [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad [6] = '{32'h0000_0040, STAT_A, STAT_A, STAT_A, 32'h0000_0044, STAT_A};
        logic [31:0] wd [6] = '{32'h1, 32'h0, 32'h4, 32'h0, 32'h0, 32'h4};
        logic [31:0] exr[6] = '{32'h1234_5678, 32'h4, 32'h4, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        int          lat[6] = '{18, 2, 2, 2, 18, 2};
        int          rqc[6] = '{16, 0, 0, 0, 16, 0};
        ack_delay = 0;
        for (int i = 0; i < 6; i++) begin
            push_exp(exr[i], 1'b1, lat[i], rqc[i]);
            bus_access(rd[i], !rd[i], ad[i], wd[i]);
            e = sb.pop_front();
            tests_run++;
            if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 || obs_rdata !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL timeout_step_%0d: got lat=%0d req=%0d rdata=%h, expected lat=%0d req=%0d rdata=%h",
                         i, obs_lat, obs_req, obs_rdata, e.latency, e.req_cycles, e.rdata);
            end
        end
    endtask

    task automatic test_misaligned_and_both();
        exp_t e;
        logic        rd [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        wr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [9] = '{LED_A, 32'h8000_0006, 32'h0000_0012, STAT_A, LED_A, STAT_A, STAT_A, STAT_A, STAT_A};
        logic [31:0] wd [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3C, 32'h0, 32'h7, 32'h0, 32'h2};
        logic [31:0] exr[9] = '{32'h12, 32'h0, 32'h0, 32'h1, 32'h1, 32'h3, 32'h3, 32'h2, 32'h2};
        logic [7:0]  exl[9] = '{8'h12, 8'h12, 8'h12, 8'h12, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        ack_delay = 1;
        for (int i = 0; i < 9; i++) begin
            push_exp(exr[i], 1'b1, 2, 0);
            bus_access(rd[i], wr[i], ad[i], wd[i]);
            e = sb.pop_front();
            tests_run++;
            if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 ||
                obs_rdata !== e.rdata || leds !== exl[i]) begin
                tests_failed++;
                $display("[TB] FAIL misalign_both_%0d: got lat=%0d req=%0d rdata=%h leds=%h, expected lat=%0d req=%0d rdata=%h leds=%h",
                         i, obs_lat, obs_req, obs_rdata, leds, e.latency, e.req_cycles, e.rdata, exl[i]);
            end
        end
    endtask

    task automatic test_unmapped();
        exp_t e;
        logic        rd [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ad [4] = '{32'h0000_4000, 32'h8000_000C, 32'h8000_000C, STAT_A};
        logic [31:0] wd [4] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic [31:0] exr[4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            push_exp(exr[i], 1'b1, 2, 0);
            bus_access(rd[i], !rd[i], ad[i], wd[i]);
            e = sb.pop_front();
            tests_run++;
            if (obs_lat != e.latency || obs_req != e.req_cycles || obs_ready_after !== 1'b0 ||
                obs_rdata !== e.rdata || leds !== 8'h3C) begin
                tests_failed++;
                $display("[TB] FAIL unmapped_%0d: got lat=%0d req=%0d rdata=%h leds=%h, expected lat=%0d req=%0d rdata=%h leds=3c",
                         i, obs_lat, obs_req, obs_rdata, leds, e.latency, e.req_cycles, e.rdata);
            end
        end
    endtask

    task automatic test_counter();
        exp_t        e;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] prev;
        bit          wrapped;

        push_exp(32'(edge_count), 1'b1, 2, 0);
        bus_access(1'b1, 1'b0, CNT_A, 32'h0);
        e = sb.pop_front();
        v1 = obs_rdata;
        tests_run++;
        if (obs_lat != e.latency || obs_ready_after !== 1'b0 || obs_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL counter_first: got lat=%0d rdata=%h, expected lat=%0d rdata=%h",
                     obs_lat, obs_rdata, e.latency, e.rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        push_exp(32'(edge_count), 1'b1, 2, 0);
        bus_access(1'b1, 1'b0, CNT_A, 32'h0);
        e = sb.pop_front();
        v2 = obs_rdata;
        tests_run++;
        if (obs_lat != e.latency || obs_rdata !== e.rdata || v2 - v1 !== 32'd5) begin
            tests_failed++;
            $display("[TB] FAIL counter_second: got lat=%0d rdata=%h delta=%0d, expected lat=%0d rdata=%h delta=5",
                     obs_lat, obs_rdata, v2 - v1, e.latency, e.rdata);
        end

        force dut.cycle_cnt = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC, 1'b1, 2, 0);
        bus_access(1'b1, 1'b0, CNT_A, 32'h0);
        release dut.cycle_cnt;
        e = sb.pop_front();
        tests_run++;
        if (obs_lat != e.latency || obs_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL counter_forced: got lat=%0d rdata=%h, expected lat=%0d rdata=%h",
                     obs_lat, obs_rdata, e.latency, e.rdata);
        end
        wrapped = 1'b0;
        prev    = dut.cycle_cnt;
        repeat (8) begin
            @(posedge clk); #1;
            if (prev === 32'hFFFF_FFFF && dut.cycle_cnt === 32'h0) wrapped = 1'b1;
            prev = dut.cycle_cnt;
        end
        tests_run++;
        if (!wrapped) begin
            tests_failed++;
            $display("[TB] FAIL counter_wrap: got no FFFFFFFF->0 step (now %h), expected a wrap to 0", prev);
        end
        push_exp(32'h0, 1'b0, 2, 0);
        bus_access(1'b1, 1'b0, CNT_A, 32'h0);
        e = sb.pop_front();
        tests_run++;
        if (obs_lat != e.latency || obs_rdata < 32'd1 || obs_rdata > 32'd8) begin
            tests_failed++;
            $display("[TB] FAIL counter_after_wrap: got lat=%0d rdata=%h, expected lat=%0d rdata in 1..8",
                     obs_lat, obs_rdata, e.latency);
        end
    endtask

    initial begin
        test_reset();
        test_led();
        test_ram_read_write();
        test_ram_timeout();
        test_misaligned_and_both();
        test_unmapped();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits between the multicycle core's memory-control outputs (memory_read, memory_write, address, write data) and the on-chip RAM plus a small memory-mapped I/O region.
- Decodes each access to one target: RAM, the LED register, the cycle counter or the status register.
- Runs a req/ack handshake with a RAM of variable latency, with a timeout.
- Returns read data with a one-cycle cpu_ready pulse.

Parameters:
- RAM_ADDR_W, 12, RAM word-address width (RAM size = 4*2^RAM_ADDR_W bytes).
- LED_W, 8, LED register width.
- TIMEOUT, 16, maximum cycles to wait for ram_ack before the access is aborted.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_read  input  1  read request (level).
- cpu_write  input  1  write request (level).
- cpu_addr  input  32  byte address.
- cpu_wdata  input  32  write data.
- cpu_rdata  output  32  read data, valid when cpu_ready=1, held until the next accepted read.
- cpu_ready  output  1  one-cycle completion pulse.
- ram_req  output  1  RAM request, held until ack or timeout.
- ram_we  output  1  RAM write enable, qualified by ram_req.
- ram_addr  output  RAM_ADDR_W  RAM word address (cpu_addr[RAM_ADDR_W+1:2]).
- ram_wdata  output  32  RAM write data.
- ram_ack  input  1  RAM completion, single-cycle pulse.
- ram_rdata  input  32  RAM read data, valid with ram_ack.
- leds  output  LED_W  LED register contents.

Behaviour:
- Reset state (asynchronous, applied immediately, including mid-access):
  - cpu_rdata=0, cpu_ready=0, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - leds=0, cycle counter=0, status=0, FSM=IDLE.
  - An outstanding RAM request is dropped with no completion.
- Address map:
  - 0x0000_0000 .. RAM_BYTES-1: RAM.
  - 0x8000_0000: LED register, R/W. Reads return the value zero-extended; writes take cpu_wdata[LED_W-1:0].
  - 0x8000_0004: cycle counter, read-only. 32-bit free-running, +1 every cycle, wraps 0xFFFF_FFFF->0.
  - 0x8000_0008: status, R/W1C.
    - bit0: misaligned access.
    - bit1: read and write requested together.
    - bit2: RAM timeout.
    - Bits are sticky; writing 1 clears a bit. If a clear and a set hit the same bit in one cycle, the set wins.
  - Any other address: read returns 0, write is ignored, no status bit set.
- FSM states: IDLE, RAM_WAIT, RESP.
  - IDLE: a request is accepted when cpu_read|cpu_write is high at a clock edge.
    - Both high: treated as a write; status bit1 set.
    - cpu_addr[1:0]!=0: no target access; status bit0 set; read data=0; go to RESP.
    - MMIO or unmapped address: the access is performed at the accept edge (read data captured); go to RESP.
    - RAM address: ram_req=1; ram_we, ram_addr and ram_wdata registered; timeout counter=0; go to RAM_WAIT.
  - RAM_WAIT:
    - ram_req and all ram_* outputs stay stable.
    - ram_ack high at an edge: ram_req=0; if it was a read, capture ram_rdata; go to RESP.
    - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack: ram_req=0, status bit2 set, read data=0xDEAD_BEEF, go to RESP.
    - A ram_ack arriving outside RAM_WAIT is ignored.
  - RESP: cpu_ready=1 for exactly one cycle, cpu_rdata valid (on a write, cpu_rdata holds its previous value); next state is IDLE.
- Requester rules: the requester deasserts its request during the RESP cycle. A request still high in IDLE is treated as a new access.
- Latency: if accepted at edge N, cpu_ready is high in the cycle after edge N+1.
  - MMIO, unmapped and misaligned accesses: 2 cycles.
  - RAM: 2 cycles + RAM wait cycles.
- Counter: increments in every state, including during accesses. A read returns the value sampled at the accept edge.

Test Plan:
- Reset mid RAM_WAIT (ram_req=1), rst_n low -> ram_req=0 immediately, leds=0, status=0; after release, no cpu_ready occurs until a new request.
- Write 0x0000_00A5 to 0x8000_0000, then read 0x8000_0000 -> leds=0xA5, read returns 0x0000_00A5, each access has cpu_ready exactly 2 cycles after accept.
- RAM read of 0x0000_0010 with ram_ack 3 cycles after ram_req, ram_rdata=0x1234_5678 -> ram_addr=4, ram_we=0, cpu_rdata=0x1234_5678, cpu_ready one cycle after ack.
- RAM write with no ack, TIMEOUT=16 -> ram_req drops after 16 cycles, status=0x4, cpu_ready pulses; next read of status returns 0x4; writing 0x4 to status then reading it returns 0.
- Read 0x8000_0006 (misaligned) -> cpu_rdata=0, status bit0=1, no ram_req. Then cpu_read and cpu_write high together at 0x8000_0000 with wdata=0x3C -> leds=0x3C, status bit1=1.
- Counter: read 0x8000_0004 twice, with the accepts 5 cycles apart -> second value = first + 5. Force the counter near 0xFFFF_FFFF -> observe the wrap to 0.
